// File: rtl/mem_responder.sv
// mem_responder: memory-side end of the processor-to-memory bus.
// Grants each LOAD/STORE a transaction tag combinationally, then returns
// load data tagged with that number a fixed number of cycles later.
module mem_responder #(
    parameter int MEM_LINES   = 1024,
    parameter int MEM_LATENCY = 4,
    parameter int NUM_TAGS    = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [63:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);

    localparam int         IDX_W     = $clog2(MEM_LINES);
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    // A one-cycle latency completes straight out of the accepting edge and
    // never occupies a slot.
    localparam bit         IMMEDIATE = (MEM_LATENCY == 1);
    // The slot counter holds the number of further edges to wait before the
    // completing edge, so the acceptance edge itself already counts as one.
    localparam logic [3:0] COUNT_INIT = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

    logic [63:0]         mem_q [MEM_LINES];

    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [NUM_TAGS-1:0] is_load_q, is_load_d;
    logic [3:0]          count_q [NUM_TAGS];
    logic [3:0]          count_d [NUM_TAGS];
    logic [63:0]         snap_q  [NUM_TAGS];
    logic [63:0]         snap_d  [NUM_TAGS];
    logic [3:0]          tag_q, tag_d;
    logic [63:0]         data_q, data_d;

    logic                is_load_cmd;
    logic                is_store_cmd;
    logic                addr_ok;
    logic                free_found;
    logic                accept;
    logic [3:0]          grant_idx;
    logic [IDX_W-1:0]    word_idx;
    logic [63:0]         read_word;
    logic                unused_addr_bits;

    // Byte offset within the 64-bit word carries no information here.
    assign unused_addr_bits = ^proc2mem_addr[2:0];
    assign word_idx         = proc2mem_addr[3 +: IDX_W];
    assign read_word        = mem_q[word_idx];

    // Decide whether this cycle's command is accepted and which tag it gets.
    always_comb begin
        is_load_cmd  = (proc2mem_command == BUS_LOAD);
        is_store_cmd = (proc2mem_command == BUS_STORE);
        addr_ok      = (proc2mem_addr[63:3+IDX_W] == '0);
        free_found   = 1'b0;
        grant_idx    = 4'd0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                grant_idx  = 4'(i);
            end
        end
        accept            = !reset && (is_load_cmd || is_store_cmd) && addr_ok && free_found;
        mem2proc_response = accept ? (grant_idx + 4'd1) : 4'd0;
    end

    // Advance every outstanding slot, retire the one that is due, and claim
    // the granted slot for a newly accepted command.
    always_comb begin
        busy_d    = busy_q;
        is_load_d = is_load_q;
        count_d   = count_q;
        snap_d    = snap_q;
        tag_d     = 4'd0;
        data_d    = 64'd0;

        for (int i = 0; i < NUM_TAGS; i++) begin
            if (busy_q[i]) begin
                if (count_q[i] == 4'd0) begin
                    busy_d[i] = 1'b0;
                    if (is_load_q[i]) begin
                        tag_d  = 4'(i + 1);
                        data_d = snap_q[i];
                    end
                end else begin
                    count_d[i] = count_q[i] - 4'd1;
                end
            end
        end

        if (accept) begin
            if (IMMEDIATE) begin
                if (is_load_cmd) begin
                    tag_d  = grant_idx + 4'd1;
                    data_d = read_word;
                end
            end else begin
                for (int i = 0; i < NUM_TAGS; i++) begin
                    if (grant_idx == 4'(i)) begin
                        busy_d[i]    = 1'b1;
                        is_load_d[i] = is_load_cmd;
                        count_d[i]   = COUNT_INIT;
                        snap_d[i]    = read_word;
                    end
                end
            end
        end
    end

    // Slot bookkeeping and the registered load-return outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q    <= '0;
            is_load_q <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                count_q[i] <= 4'd0;
                snap_q[i]  <= 64'd0;
            end
            tag_q  <= 4'd0;
            data_q <= 64'd0;
        end else begin
            busy_q    <= busy_d;
            is_load_q <= is_load_d;
            count_q   <= count_d;
            snap_q    <= snap_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
        end
    end

    // Memory array; deliberately untouched by reset so contents survive it.
    always_ff @(posedge clock) begin
        if (accept && is_store_cmd) begin
            mem_q[word_idx] <= proc2mem_data;
        end
    end

    assign mem2proc_tag  = tag_q;
    assign mem2proc_data = data_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: drives two responders (15 tags and 2 tags) with the
// same directed command stream and checks both against a cycle-indexed
// model of tag availability, memory contents and scheduled load returns.
module tb_mem_responder;

    localparam int         LAT       = 4;
    localparam int         DEPTH     = 128;
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam logic [1:0] CMD_BAD   = 2'd3;

    bit          clock;
    logic        reset;
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  resp0, resp1, tag0, tag1;
    logic [63:0] data0, data1;

    logic [3:0]  respAct [2];
    logic [3:0]  tagAct  [2];
    logic [63:0] dataAct [2];

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    bit          outsValid  = 1'b0;

    int          numTags [2] = '{15, 2};
    int          freeAt  [2][16];
    bit [63:0]   memModel[2][1024];
    bit          memKnown[2][1024];
    bit [3:0]    expTag  [2][DEPTH];
    bit [63:0]   expData [2][DEPTH];
    bit          expKnown[2][DEPTH];
    logic [3:0]  expResp;
    logic [9:0]  word;

    always #5 clock = ~clock;

    mem_responder u_dutWide (
        .clock            (clock),
        .reset            (reset),
        .proc2mem_command (cmd),
        .proc2mem_addr    (addr),
        .proc2mem_data    (wdata),
        .mem2proc_response(resp0),
        .mem2proc_data    (data0),
        .mem2proc_tag     (tag0)
    );

    mem_responder #(.NUM_TAGS(2)) u_dutNarrow (
        .clock            (clock),
        .reset            (reset),
        .proc2mem_command (cmd),
        .proc2mem_addr    (addr),
        .proc2mem_data    (wdata),
        .mem2proc_response(resp1),
        .mem2proc_data    (data1),
        .mem2proc_tag     (tag1)
    );

    assign respAct[0] = resp0;
    assign respAct[1] = resp1;
    assign tagAct[0]  = tag0;
    assign tagAct[1]  = tag1;
    assign dataAct[0] = data0;
    assign dataAct[1] = data1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge that opens it, leaving
    // time inside the cycle for direct checks.
    task automatic applyStimulus(input logic r, input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
        @(posedge clock);
        #1;
        reset = r;
        cmd   = c;
        addr  = a;
        wdata = d;
        #2;
    endtask

    task automatic idle();
        applyStimulus(1'b0, CMD_NONE, 64'd0, 64'd0);
    endtask

    // Mid-cycle: compare both DUTs against the model, then fold this cycle's
    // command into the model.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            expResp = 4'd0;
            if (!reset && (cmd == CMD_LOAD || cmd == CMD_STORE) && addr[63:13] == 51'd0) begin
                for (int t = numTags[i]; t >= 1; t--) begin
                    if (freeAt[i][t] <= cyc) expResp = 4'(t);
                end
            end
            checkOutput($sformatf("response[%0d]", i), {60'd0, respAct[i]}, {60'd0, expResp});
            if (outsValid) begin
                checkOutput($sformatf("tag[%0d]", i), {60'd0, tagAct[i]}, {60'd0, expTag[i][cyc]});
                if (expTag[i][cyc] == 4'd0 || expKnown[i][cyc]) begin
                    checkOutput($sformatf("data[%0d]", i), dataAct[i], expData[i][cyc]);
                end
            end
            if (expResp != 4'd0) begin
                word = addr[12:3];
                freeAt[i][expResp] = cyc + LAT;
                if (cmd == CMD_LOAD) begin
                    if (cyc + LAT < DEPTH) begin
                        expTag[i][cyc + LAT]   = expResp;
                        expData[i][cyc + LAT]  = memModel[i][word];
                        expKnown[i][cyc + LAT] = memKnown[i][word];
                    end
                end else begin
                    memModel[i][word] = wdata;
                    memKnown[i][word] = 1'b1;
                end
            end
            if (reset) begin
                for (int t = 0; t < 16; t++) freeAt[i][t] = 0;
                for (int k = cyc + 1; k < DEPTH; k++) begin
                    expTag[i][k]   = 4'd0;
                    expData[i][k]  = 64'd0;
                    expKnown[i][k] = 1'b0;
                end
            end
        end
        if (reset) outsValid = 1'b1;
        cyc++;
    end

    initial begin
        reset = 1'b1;
        cmd   = CMD_NONE;
        addr  = 64'd0;
        wdata = 64'd0;

        applyStimulus(1'b1, CMD_NONE, 64'd0, 64'd0);                       // 0
        applyStimulus(1'b1, CMD_NONE, 64'd0, 64'd0);                       // 1
        checkOutput("resetTag", {60'd0, tag0}, 64'd0);
        checkOutput("resetData", data0, 64'd0);

        // Store then load to the same word.
        applyStimulus(1'b0, CMD_STORE, 64'h40, 64'hDEADBEEF_00000001);    // 2
        checkOutput("storeRespWide", {60'd0, resp0}, 64'd1);
        checkOutput("storeRespNarrow", {60'd0, resp1}, 64'd1);
        applyStimulus(1'b0, CMD_LOAD, 64'h40, 64'd0);                      // 3
        checkOutput("loadRespWide", {60'd0, resp0}, 64'd2);
        repeat (3) idle();                                                  // 4..6
        checkOutput("storeNoTag", {60'd0, tag0}, 64'd0);
        idle();                                                             // 7
        checkOutput("rawTag", {60'd0, tag0}, 64'd2);
        checkOutput("rawData", data0, 64'hDEADBEEF_00000001);
        idle();                                                             // 8

        // Preload three words; the narrow DUT runs out of tags on the third.
        applyStimulus(1'b0, CMD_STORE, 64'h00, 64'hA);                     // 9
        applyStimulus(1'b0, CMD_STORE, 64'h08, 64'hB);                     // 10
        applyStimulus(1'b0, CMD_STORE, 64'h10, 64'hC);                     // 11
        checkOutput("preloadRespWide", {60'd0, resp0}, 64'd3);
        checkOutput("preloadRespNarrow", {60'd0, resp1}, 64'd0);
        repeat (4) idle();                                                  // 12..15

        // A load every cycle: wide DUT gets 1..4 then reuses 1, narrow DUT
        // exhausts after two and re-grants tag 1 as it completes.
        applyStimulus(1'b0, CMD_LOAD, 64'h00, 64'd0);                      // 16
        checkOutput("b2bResp0Wide", {60'd0, resp0}, 64'd1);
        checkOutput("b2bResp0Narrow", {60'd0, resp1}, 64'd1);
        applyStimulus(1'b0, CMD_LOAD, 64'h08, 64'd0);                      // 17
        checkOutput("b2bResp1Wide", {60'd0, resp0}, 64'd2);
        checkOutput("b2bResp1Narrow", {60'd0, resp1}, 64'd2);
        applyStimulus(1'b0, CMD_LOAD, 64'h10, 64'd0);                      // 18
        checkOutput("b2bResp2Wide", {60'd0, resp0}, 64'd3);
        checkOutput("b2bResp2Narrow", {60'd0, resp1}, 64'd0);
        applyStimulus(1'b0, CMD_LOAD, 64'h40, 64'd0);                      // 19
        checkOutput("b2bResp3Narrow", {60'd0, resp1}, 64'd0);
        applyStimulus(1'b0, CMD_LOAD, 64'h40, 64'd0);                      // 20
        checkOutput("reuseRespWide", {60'd0, resp0}, 64'd1);
        checkOutput("reuseRespNarrow", {60'd0, resp1}, 64'd1);
        checkOutput("b2bTagA", {60'd0, tag0}, 64'd1);
        checkOutput("b2bDataA", data0, 64'hA);
        idle();                                                             // 21
        checkOutput("b2bDataB", data0, 64'hB);
        idle();                                                             // 22
        checkOutput("b2bTagC", {60'd0, tag0}, 64'd3);
        checkOutput("b2bDataC", data0, 64'hC);
        idle();                                                             // 23
        idle();                                                             // 24
        checkOutput("reuseTagNarrow", {60'd0, tag1}, 64'd1);
        checkOutput("reuseDataNarrow", data1, 64'hDEADBEEF_00000001);
        idle();                                                             // 25

        // Out-of-range address is refused and never completes.
        applyStimulus(1'b0, CMD_LOAD, 64'h1_0000, 64'd0);                  // 26
        checkOutput("rangeResp", {60'd0, resp0}, 64'd0);
        for (int k = 0; k < 16; k++) begin                                  // 27..42
            idle();
            checkOutput("rangeNoTag", {60'd0, tag0}, 64'd0);
        end

        // Reset drops an outstanding load; command during reset is refused.
        applyStimulus(1'b0, CMD_LOAD, 64'h08, 64'd0);                      // 43
        checkOutput("preResetResp", {60'd0, resp0}, 64'd1);
        applyStimulus(1'b1, CMD_LOAD, 64'h00, 64'd0);                      // 44
        checkOutput("inResetResp", {60'd0, resp0}, 64'd0);
        applyStimulus(1'b0, CMD_LOAD, 64'h08, 64'd0);                      // 45
        checkOutput("postResetResp", {60'd0, resp0}, 64'd1);
        idle();                                                             // 46
        idle();                                                             // 47
        checkOutput("droppedTag", {60'd0, tag0}, 64'd0);
        idle();                                                             // 48
        idle();                                                             // 49
        checkOutput("postResetTag", {60'd0, tag0}, 64'd1);
        checkOutput("postResetData", data0, 64'hB);

        // Command 3 writes nothing; loads snapshot at acceptance time.
        applyStimulus(1'b0, CMD_BAD, 64'h40, 64'h1234);                    // 50
        checkOutput("badCmdResp", {60'd0, resp0}, 64'd0);
        applyStimulus(1'b0, CMD_LOAD, 64'h40, 64'd0);                      // 51
        applyStimulus(1'b0, CMD_STORE, 64'h18, 64'h55);                    // 52
        applyStimulus(1'b0, CMD_LOAD, 64'h18, 64'd0);                      // 53
        checkOutput("snapRespNarrow", {60'd0, resp1}, 64'd0);
        applyStimulus(1'b0, CMD_STORE, 64'h18, 64'h66);                    // 54
        checkOutput("fourthRespWide", {60'd0, resp0}, 64'd4);
        idle();                                                             // 55
        checkOutput("badCmdData", data0, 64'hDEADBEEF_00000001);
        idle();                                                             // 56
        idle();                                                             // 57
        checkOutput("snapTag", {60'd0, tag0}, 64'd3);
        checkOutput("snapData", data0, 64'h55);
        repeat (3) idle();                                                  // 58..60

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
